// File: rtl/tpu_panel_cmd_ctrl.sv
// Front-panel command controller for the FPGA TPU: debounced buttons, matrix-memory writes and
// the start/busy/done handshake. Optional address auto-increment: define PANEL_ADDR_AUTOINC_EN.
module tpu_panel_cmd_ctrl #(
  parameter int NUM_BTNS        = 5,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int ADDR_W          = 6,
  parameter int DATA_W          = 16,
  parameter int START_TIMEOUT   = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [15:0]         switches,
  input  logic [NUM_BTNS-1:0] btn_raw,
  output logic                mem_we,
  output logic [1:0]          mem_sel,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic                tpu_start,
  input  logic                tpu_busy,
  input  logic                tpu_done,
  output logic                busy_led,
  output logic                done_led,
  output logic                err_led,
  output logic [2:0]          state_dbg
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TO_W = $clog2(START_TIMEOUT + 1);
  localparam int HI_W = DATA_W - 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WRITE     = 3'd1,
    ST_START     = 3'd2,
    ST_WAIT_BUSY = 3'd3,
    ST_COMPUTE   = 3'd4,
    ST_DONE      = 3'd5
  } state_e;

  logic [NUM_BTNS-1:0] sync1_r, sync2_r, stable_r, stable_d_r, pulse_s;
  logic [DB_W-1:0]     db_cnt_r [NUM_BTNS];

  state_e              state_r, state_n_s;
  logic [TO_W-1:0]     to_cnt_r;
  logic [ADDR_W-1:0]   addr_reg_r;
  logic [HI_W-1:0]     hi_byte_r;
  logic                busy_d_r;

  logic cmd_center_s, cmd_up_s, cmd_down_s, cmd_right_s, cmd_left_s;
  logic do_write_s, ld_addr_s, ld_hi_s, set_err_s, clr_err_s, set_done_s, clr_done_s;
  logic unused_s;

  assign unused_s = ^{switches[15:10], pulse_s};

  // Button synchronisers and per-button stability counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r    <= '0;
      sync2_r    <= '0;
      stable_r   <= '0;
      stable_d_r <= '0;
      for (int i = 0; i < NUM_BTNS; i++) db_cnt_r[i] <= '0;
    end else begin
      sync1_r    <= btn_raw;
      sync2_r    <= sync1_r;
      stable_d_r <= stable_r;
      for (int i = 0; i < NUM_BTNS; i++) begin
        if (sync2_r[i] == stable_r[i]) begin
          db_cnt_r[i] <= '0;
        end else if (db_cnt_r[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          stable_r[i] <= sync2_r[i];
          db_cnt_r[i] <= '0;
        end else begin
          db_cnt_r[i] <= db_cnt_r[i] + DB_W'(1);
        end
      end
    end
  end

  assign pulse_s = stable_r & ~stable_d_r;

  // Fixed command priority: center > up > down > right > left.
  always_comb begin
    cmd_center_s = pulse_s[0];
    cmd_up_s     = ~pulse_s[0] & pulse_s[1];
    cmd_down_s   = ~pulse_s[0] & ~pulse_s[1] & pulse_s[4];
    cmd_right_s  = ~pulse_s[0] & ~pulse_s[1] & ~pulse_s[4] & pulse_s[3];
    cmd_left_s   = ~pulse_s[0] & ~pulse_s[1] & ~pulse_s[4] & ~pulse_s[3] & pulse_s[2];
  end

  // Next-state and command-effect decode.
  always_comb begin
    state_n_s  = state_r;
    do_write_s = 1'b0;
    ld_addr_s  = 1'b0;
    ld_hi_s    = 1'b0;
    set_err_s  = 1'b0;
    clr_err_s  = 1'b0;
    set_done_s = 1'b0;
    clr_done_s = 1'b0;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (cmd_center_s) begin
          state_n_s  = ST_IDLE;
          clr_done_s = 1'b1;
          clr_err_s  = 1'b1;
        end else if (cmd_up_s) begin
          state_n_s  = ST_START;
          clr_done_s = 1'b1;
        end else if (cmd_down_s) begin
          if (switches[9:8] == 2'b11) begin
            set_err_s = 1'b1;
          end else begin
            state_n_s  = ST_WRITE;
            do_write_s = 1'b1;
          end
        end else if (cmd_right_s) begin
          ld_hi_s = 1'b1;
        end else if (cmd_left_s) begin
          ld_addr_s = 1'b1;
        end else begin
          state_n_s = state_r;
        end
      end
      ST_WRITE: begin
        state_n_s = ST_IDLE;
        if (cmd_center_s) begin
          clr_done_s = 1'b1;
          clr_err_s  = 1'b1;
        end else begin
          clr_done_s = 1'b0;
        end
      end
      ST_START: begin
        if (cmd_center_s) begin
          state_n_s  = ST_IDLE;
          clr_done_s = 1'b1;
          set_err_s  = 1'b1;
        end else begin
          state_n_s = ST_WAIT_BUSY;
        end
      end
      ST_WAIT_BUSY: begin
        if (cmd_center_s) begin
          state_n_s  = ST_IDLE;
          clr_done_s = 1'b1;
          set_err_s  = 1'b1;
        end else if (tpu_busy) begin
          state_n_s = ST_COMPUTE;
        end else if (tpu_done) begin
          state_n_s  = ST_DONE;
          set_done_s = 1'b1;
        end else if (to_cnt_r == TO_W'(START_TIMEOUT)) begin
          state_n_s = ST_IDLE;
          set_err_s = 1'b1;
        end else begin
          state_n_s = ST_WAIT_BUSY;
        end
      end
      ST_COMPUTE: begin
        if (cmd_center_s) begin
          state_n_s  = ST_IDLE;
          clr_done_s = 1'b1;
          set_err_s  = 1'b1;
        end else if (tpu_done || (busy_d_r && !tpu_busy)) begin
          state_n_s  = ST_DONE;
          set_done_s = 1'b1;
        end else begin
          state_n_s = ST_COMPUTE;
        end
      end
      default: begin
        state_n_s = ST_IDLE;
      end
    endcase
  end

  // State, timeout counter, panel registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      to_cnt_r   <= '0;
      addr_reg_r <= '0;
      hi_byte_r  <= '0;
      busy_d_r   <= 1'b0;
      mem_we     <= 1'b0;
      mem_sel    <= 2'b00;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      tpu_start  <= 1'b0;
      busy_led   <= 1'b0;
      done_led   <= 1'b0;
      err_led    <= 1'b0;
    end else begin
      state_r   <= state_n_s;
      busy_d_r  <= tpu_busy;
      to_cnt_r  <= (state_r == ST_WAIT_BUSY) ? to_cnt_r + TO_W'(1) : '0;
      mem_we    <= do_write_s;
      tpu_start <= (state_n_s == ST_START);
      busy_led  <= (state_n_s == ST_START) || (state_n_s == ST_WAIT_BUSY) ||
                   (state_n_s == ST_COMPUTE);
      if (do_write_s) begin
        mem_sel   <= switches[9:8];
        mem_addr  <= addr_reg_r;
        mem_wdata <= {hi_byte_r, switches[7:0]};
      end
      if (ld_hi_s) hi_byte_r <= switches[HI_W-1:0];
`ifdef PANEL_ADDR_AUTOINC_EN
      // Step past the address just written so sequential fills need no re-press.
      if (ld_addr_s) addr_reg_r <= switches[ADDR_W-1:0];
      else if (state_r == ST_WRITE) addr_reg_r <= addr_reg_r + ADDR_W'(1);
`else
      if (ld_addr_s) addr_reg_r <= switches[ADDR_W-1:0];
`endif
      if (set_done_s) done_led <= 1'b1;
      else if (clr_done_s) done_led <= 1'b0;
      if (set_err_s) err_led <= 1'b1;
      else if (clr_err_s) err_led <= 1'b0;
    end
  end

  assign state_dbg = state_r;

endmodule

// File: tb/tb_tpu_panel_cmd_ctrl.sv
// Scoreboard bench for tpu_panel_cmd_ctrl: directed button sequences push expected write/start
// events, an independent monitor pops and compares them as the DUT presents them.
module tb_tpu_panel_cmd_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] switches;
  logic [4:0]  btn_raw;
  logic        mem_we;
  logic [1:0]  mem_sel;
  logic [5:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic        tpu_start;
  logic        tpu_busy;
  logic        tpu_done;
  logic        busy_led, done_led, err_led;
  logic [2:0]  state_dbg;

  typedef struct packed {
    logic        kind;   // 0 write, 1 start
    logic [1:0]  sel;
    logic [5:0]  addr;
    logic [15:0] wdata;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  failures = 0;
  int  cyc = 0;
  int  press_cyc = 0;
  int  last_we_cyc = -1;
  int  last_start_cyc = -1;
  int  we_count = 0;
  int  model_en = 0;
  int  model_busy_len = 20;

  tpu_panel_cmd_ctrl #(
    .NUM_BTNS(5), .DEBOUNCE_CYCLES(4), .ADDR_W(6), .DATA_W(16), .START_TIMEOUT(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .switches(switches), .btn_raw(btn_raw),
    .mem_we(mem_we), .mem_sel(mem_sel), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .tpu_start(tpu_start), .tpu_busy(tpu_busy), .tpu_done(tpu_done),
    .busy_led(busy_led), .done_led(done_led), .err_led(err_led), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] all_outs();
    return {mem_we, mem_sel, mem_addr, mem_wdata, tpu_start, busy_led, done_led, err_led,
            state_dbg};
  endfunction

  task automatic push_wr(input logic [1:0] sel, input logic [5:0] addr, input logic [15:0] wd);
    exp_q.push_back('{kind: 1'b0, sel: sel, addr: addr, wdata: wd});
  endtask

  task automatic push_start();
    exp_q.push_back('{kind: 1'b1, sel: 2'b00, addr: 6'h00, wdata: 16'h0000});
  endtask

  task automatic press(input logic [4:0] mask, input int hold);
    @(posedge clk); #1;
    btn_raw   = mask;
    press_cyc = cyc;
    repeat (hold) @(posedge clk);
    #1 btn_raw = 5'b00000;
    repeat (12) @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, input string name);
    int n = 0;
    while (state_dbg !== s && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, {29'd0, state_dbg}, {29'd0, s});
  endtask

  // Monitor: every write strobe or start pulse must match the head of the expected queue.
  always @(negedge clk) begin
    if (rst_n && (mem_we || tpu_start)) begin
      if (mem_we) begin
        we_count++;
        last_we_cyc = cyc;
      end
      if (tpu_start) last_start_cyc = cyc;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected_event we=%0b start=%0b expected=none", mem_we, tpu_start);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        check("sb_kind", {31'd0, tpu_start}, {31'd0, e.kind});
        if (!e.kind) begin
          check("sb_wr_sel", {30'd0, mem_sel}, {30'd0, e.sel});
          check("sb_wr_addr", {26'd0, mem_addr}, {26'd0, e.addr});
          check("sb_wr_wdata", {16'd0, mem_wdata}, {16'd0, e.wdata});
        end
      end
    end
  end

  // TPU model: after a start pulse raise busy 3 cycles later, hold it, then pulse done.
  initial begin
    tpu_busy = 1'b0;
    tpu_done = 1'b0;
    forever begin
      @(negedge clk);
      if (model_en != 0 && rst_n && tpu_start) begin
        repeat (3) @(posedge clk);
        #1 tpu_busy = 1'b1;
        repeat (model_busy_len) @(posedge clk);
        #1 tpu_busy = 1'b0;
        tpu_done = 1'b1;
        @(posedge clk);
        #1 tpu_done = 1'b0;
      end
    end
  end

  initial begin
    logic [5:0] a2, aw2;
    int we_before;
`ifdef PANEL_ADDR_AUTOINC_EN
    a2 = 6'h13; aw2 = 6'h00;
`else
    a2 = 6'h12; aw2 = 6'h3F;
`endif
    rst_n    = 1'b0;
    switches = 16'h0000;
    btn_raw  = 5'b00000;

    // 1: reset
    #50 check("reset_outputs", all_outs(), 32'd0);
    #50 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post_reset_outputs", all_outs(), 32'd0);

    // 2: glitch rejected, real press gives one write 7 cycles after press
    we_before = we_count;
    press(5'b10000, 3);
    check("glitch_no_write", we_count, we_before);
    push_wr(2'b00, 6'h00, 16'h0000);
    press(5'b10000, 10);
    check("press_write_count", we_count, we_before + 1);
    check("press_latency", last_we_cyc - press_cyc, 7);

    // 3: address/high-byte loads and writes
    switches = 16'h0012; press(5'b00100, 10);
    switches = 16'h003C; press(5'b01000, 10);
    switches = 16'h0100;
    push_wr(2'b01, 6'h12, 16'h3C00); press(5'b10000, 10);
    push_wr(2'b01, a2, 16'h3C00);    press(5'b10000, 10);
    switches = 16'h003F; press(5'b00100, 10);
    switches = 16'h0255;
    push_wr(2'b10, 6'h3F, 16'h3C55); press(5'b10000, 10);
    push_wr(2'b10, aw2, 16'h3C55);   press(5'b10000, 10);
    we_before = we_count;
    switches = 16'h0300; press(5'b10000, 10);
    check("sel11_no_write", we_count, we_before);
    check("sel11_err", {31'd0, err_led}, 32'd1);
    press(5'b00001, 10);
    check("center_clears_err", {31'd0, err_led}, 32'd0);

    // 4: full start/busy/done handshake
    model_en = 1; model_busy_len = 20;
    push_start(); press(5'b00010, 10);
    wait_state(3'd4, 40, "reach_compute");
    check("busy_led_compute", {31'd0, busy_led}, 32'd1);
    wait_state(3'd5, 60, "reach_done");
    check("done_led_set", {31'd0, done_led}, 32'd1);
    check("busy_led_done", {31'd0, busy_led}, 32'd0);
    repeat (5) @(negedge clk);
    check("done_led_sticky", {31'd0, done_led}, 32'd1);
    check("done_state_held", {29'd0, state_dbg}, 32'd5);

    // 5: start timeout with busy never rising
    model_en = 0;
    push_start(); press(5'b00010, 10);
    check("up_clears_done", {31'd0, done_led}, 32'd0);
    while (cyc < last_start_cyc + 16) @(negedge clk);
    check("timeout_not_early", {31'd0, err_led}, 32'd0);
    while (cyc < last_start_cyc + 20) @(negedge clk);
    check("timeout_err", {31'd0, err_led}, 32'd1);
    check("timeout_state", {29'd0, state_dbg}, 32'd0);
    check("timeout_busy_led", {31'd0, busy_led}, 32'd0);

    // 6: abort mid-COMPUTE, up+down priority, async reset mid-COMPUTE
    press(5'b00001, 10);
    check("center_idle_clear", {31'd0, err_led}, 32'd0);
    model_en = 1; model_busy_len = 60;
    push_start(); press(5'b00010, 10);
    wait_state(3'd4, 40, "reach_compute2");
    press(5'b00001, 10);
    check("abort_state", {29'd0, state_dbg}, 32'd0);
    check("abort_err", {31'd0, err_led}, 32'd1);
    check("abort_busy_led", {31'd0, busy_led}, 32'd0);
    repeat (70) @(negedge clk);
    check("abort_done_ignored", {31'd0, done_led}, 32'd0);
    we_before = we_count;
    push_start(); press(5'b10010, 10);
    check("updown_no_write", we_count, we_before);
    wait_state(3'd4, 40, "reach_compute3");
    @(negedge clk); #2 rst_n = 1'b0;
    #1 check("async_reset_outputs", all_outs(), 32'd0);
    repeat (70) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("sb_drained", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time limit so the bench never hangs.
  initial begin
    #500000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "time limit");
  end

endmodule
